// File: rtl/gpio_loader_pkg.sv
// Shared types and sizing helpers for the GPIO serial loader.
// Imported by the loader, its tick generator and its interface.
package gpio_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    LOAD,
    DONE
  } state_t;

  localparam int DEF_TOTAL_PADS = 38;
  localparam int DEF_AREA1PADS  = 19;
  localparam int DEF_CFG_BITS   = 13;

  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/gpio_serial_loader_if.sv
// Host-side request/config bus of the GPIO serial loader.
// The loader is the slave; the host is the master.
interface gpio_serial_loader_if
  import gpio_loader_pkg::*;
#(
  parameter int IDX_W    = 6,
  parameter int CFG_BITS = DEF_CFG_BITS
);

  logic                start;
  logic                busy;
  logic                done;
  logic [IDX_W-1:0]    cfg_idx_1;
  logic [IDX_W-1:0]    cfg_idx_2;
  logic [CFG_BITS-1:0] cfg_data_1;
  logic [CFG_BITS-1:0] cfg_data_2;

  modport master (
    output start,
    output cfg_data_1,
    output cfg_data_2,
    input  busy,
    input  done,
    input  cfg_idx_1,
    input  cfg_idx_2
  );

  modport slave (
    input  start,
    input  cfg_data_1,
    input  cfg_data_2,
    output busy,
    output done,
    output cfg_idx_1,
    output cfg_idx_2
  );

endinterface

// File: rtl/gpio_serial_tick.sv
// Phase tick: pulses on the last cycle of every CLK_HALF-cycle phase.
// Counter restarts whenever the loader is idle.
module gpio_serial_tick
  import gpio_loader_pkg::*;
#(
  parameter int CLK_HALF = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int W = cnt_w(CLK_HALF);
  localparam logic [W-1:0] LAST = W'(CLK_HALF - 1);

  logic [W-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!en || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/gpio_serial_loader.sv
// Shifts every pad configuration word into two GPIO control chains,
// MSB first, then strobes serial_load once both chains are full.
module gpio_serial_loader
  import gpio_loader_pkg::*;
#(
  parameter int TOTAL_PADS = DEF_TOTAL_PADS,
  parameter int AREA1PADS  = DEF_AREA1PADS,
  parameter int CFG_BITS   = DEF_CFG_BITS,
  parameter int CLK_HALF   = 1
) (
  input  logic wb_clk_i,
  input  logic wb_rstn_i,
  gpio_serial_loader_if.slave bus,
  output logic serial_clock,
  output logic serial_load,
  output logic serial_resetn,
  output logic serial_data_1,
  output logic serial_data_2
);

  localparam int L1     = AREA1PADS;
  localparam int L2     = TOTAL_PADS - AREA1PADS;
  localparam int S      = max2(L1, L2);
  localparam int OFF1   = S - L1;
  localparam int OFF2   = S - L2;
  localparam int IDX_W  = $clog2(TOTAL_PADS);
  localparam int STEP_W = cnt_w(S);
  localparam int BIT_W  = cnt_w(CFG_BITS);

  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(S - 1);
  localparam logic [BIT_W-1:0]  TOP_BIT   = BIT_W'(CFG_BITS - 1);

  state_t             state;
  logic [STEP_W-1:0]  step;
  logic [BIT_W-1:0]   bit_n;
  logic               busy_q;
  logic               done_q;
  logic               sclk_q;
  logic               load_q;
  logic               rstn_q;
  logic [IDX_W-1:0]   idx1_q;
  logic [IDX_W-1:0]   idx2_q;
  logic               tick;
  logic               real_1;
  logic               real_2;
  logic               last;
  logic [STEP_W-1:0]  step_nx;

  // Chain 1 runs pad L1-1 down to 0; chain 2 runs pad L1 upward.
  function automatic logic [IDX_W-1:0] pad1(input logic [STEP_W-1:0] s);
    int k;
    k = int'(s) - OFF1;
    return (k < 0) ? '0 : IDX_W'(AREA1PADS - 1 - k);
  endfunction

  function automatic logic [IDX_W-1:0] pad2(input logic [STEP_W-1:0] s);
    int k;
    k = int'(s) - OFF2;
    return (k < 0) ? '0 : IDX_W'(AREA1PADS + k);
  endfunction

  gpio_serial_tick #(
    .CLK_HALF (CLK_HALF)
  ) u_tick (
    .clk   (wb_clk_i),
    .rst_n (wb_rstn_i),
    .en    (busy_q),
    .tick  (tick)
  );

  assign real_1  = int'(step) >= OFF1;
  assign real_2  = int'(step) >= OFF2;
  assign step_nx = step + STEP_W'(1);
  assign last    = (step == LAST_STEP) && (bit_n == '0);

  // Selects only move on SHIFT_LO entry, so the data bits do too.
  assign serial_data_1 = busy_q & real_1 & bus.cfg_data_1[bit_n];
  assign serial_data_2 = busy_q & real_2 & bus.cfg_data_2[bit_n];

  assign serial_clock  = sclk_q;
  assign serial_load   = load_q;
  assign serial_resetn = rstn_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.cfg_idx_1 = idx1_q;
  assign bus.cfg_idx_2 = idx2_q;

  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      rstn_q <= 1'b0;
    end else begin
      rstn_q <= 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      state  <= IDLE;
      step   <= '0;
      bit_n  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      sclk_q <= 1'b0;
      load_q <= 1'b0;
      idx1_q <= '0;
      idx2_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state  <= SHIFT_LO;
            busy_q <= 1'b1;
            step   <= '0;
            bit_n  <= TOP_BIT;
            idx1_q <= pad1('0);
            idx2_q <= pad2('0);
          end
        end
        SHIFT_LO: begin
          if (tick) begin
            state  <= SHIFT_HI;
            sclk_q <= 1'b1;
          end
        end
        SHIFT_HI: begin
          if (tick) begin
            sclk_q <= 1'b0;
            if (last) begin
              state  <= LOAD;
              load_q <= 1'b1;
            end else begin
              state <= SHIFT_LO;
              if (bit_n == '0) begin
                bit_n  <= TOP_BIT;
                step   <= step_nx;
                idx1_q <= pad1(step_nx);
                idx2_q <= pad2(step_nx);
              end else begin
                bit_n <= bit_n - 1'b1;
              end
            end
          end
        end
        LOAD: begin
          if (tick) begin
            state  <= DONE;
            load_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            step   <= '0;
            bit_n  <= '0;
            idx1_q <= '0;
            idx2_q <= '0;
          end
        end
        DONE: begin
          state  <= IDLE;
          done_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_serial_loader.sv
// Directed bench: three loader builds (default, 37-pad, CLK_HALF=3)
// with a chain model that captures bits on rising serial_clock.
module tb_gpio_serial_loader;

  localparam int NB = 247;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] st = '0;
  logic [2:0] bsy, dn, sclk, sld, sres, sd1, sd2;
  logic [5:0] ci1 [3];
  logic [5:0] ci2 [3];

  int nvec = 0;
  int nerr = 0;

  function automatic logic [12:0] pat(input int p);
    return 13'(p * 331 + 97) ^ 13'(p << 8);
  endfunction

  function automatic int hh(input int i);
    return (i == 2) ? 3 : 1;
  endfunction

  gpio_serial_loader_if #(.IDX_W(6), .CFG_BITS(13)) bus0 ();
  gpio_serial_loader_if #(.IDX_W(6), .CFG_BITS(13)) bus1 ();
  gpio_serial_loader_if #(.IDX_W(6), .CFG_BITS(13)) bus2 ();

  assign bus0.start = st[0];
  assign bus1.start = st[1];
  assign bus2.start = st[2];
  assign bus0.cfg_data_1 = pat(int'(bus0.cfg_idx_1));
  assign bus0.cfg_data_2 = pat(int'(bus0.cfg_idx_2));
  assign bus1.cfg_data_1 = pat(int'(bus1.cfg_idx_1));
  assign bus1.cfg_data_2 = pat(int'(bus1.cfg_idx_2));
  assign bus2.cfg_data_1 = pat(int'(bus2.cfg_idx_1));
  assign bus2.cfg_data_2 = pat(int'(bus2.cfg_idx_2));
  assign bsy = {bus2.busy, bus1.busy, bus0.busy};
  assign dn  = {bus2.done, bus1.done, bus0.done};
  assign ci1[0] = bus0.cfg_idx_1;
  assign ci1[1] = bus1.cfg_idx_1;
  assign ci1[2] = bus2.cfg_idx_1;
  assign ci2[0] = bus0.cfg_idx_2;
  assign ci2[1] = bus1.cfg_idx_2;
  assign ci2[2] = bus2.cfg_idx_2;

  gpio_serial_loader u0 (
    .wb_clk_i(clk), .wb_rstn_i(rstn), .bus(bus0),
    .serial_clock(sclk[0]), .serial_load(sld[0]),
    .serial_resetn(sres[0]),
    .serial_data_1(sd1[0]), .serial_data_2(sd2[0])
  );

  gpio_serial_loader #(.TOTAL_PADS(37), .AREA1PADS(19)) u1 (
    .wb_clk_i(clk), .wb_rstn_i(rstn), .bus(bus1),
    .serial_clock(sclk[1]), .serial_load(sld[1]),
    .serial_resetn(sres[1]),
    .serial_data_1(sd1[1]), .serial_data_2(sd2[1])
  );

  gpio_serial_loader #(.CLK_HALF(3)) u2 (
    .wb_clk_i(clk), .wb_rstn_i(rstn), .bus(bus2),
    .serial_clock(sclk[2]), .serial_load(sld[2]),
    .serial_resetn(sres[2]),
    .serial_data_1(sd1[2]), .serial_data_2(sd2[2])
  );

  // Chain model and waveform-shape monitor, sampled on falling edges.
  bit b1 [3][2048];
  bit b2 [3][2048];
  int nsh [3];
  int nld [3];
  int ndn [3];
  int run [3];
  int ldrun [3];
  int bad_run [3];
  int bad_ld [3];
  int bad_dat [3];
  bit psc [3];
  bit pbs [3];
  bit pd1 [3];
  bit pd2 [3];

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      psc[i] <= sclk[i];
      pbs[i] <= bsy[i];
      pd1[i] <= sd1[i];
      pd2[i] <= sd2[i];
      if (rstn) begin
        if (sclk[i] && !psc[i]) begin
          b1[i][nsh[i]] <= sd1[i];
          b2[i][nsh[i]] <= sd2[i];
          nsh[i] <= nsh[i] + 1;
        end
        if (!bsy[i]) begin
          run[i] <= 0;
        end else if (sclk[i] != psc[i]) begin
          if (run[i] != hh(i)) bad_run[i] <= bad_run[i] + 1;
          run[i] <= 1;
        end else begin
          run[i] <= run[i] + 1;
        end
        if (sld[i]) begin
          ldrun[i] <= ldrun[i] + 1;
          nld[i] <= nld[i] + 1;
        end else if (ldrun[i] != 0) begin
          if (ldrun[i] != hh(i)) bad_ld[i] <= bad_ld[i] + 1;
          ldrun[i] <= 0;
        end
        if (bsy[i] && pbs[i] && (sd1[i] != pd1[i] || sd2[i] != pd2[i])
            && !(psc[i] && !sclk[i]))
          bad_dat[i] <= bad_dat[i] + 1;
        if (dn[i]) ndn[i] <= ndn[i] + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic xfer(input int i, input int exp_cyc, input bit spam,
                      output int base);
    int cyc;
    int drops;
    int d0;
    bit seen;
    base = nsh[i];
    d0 = ndn[i];
    cyc = 0;
    drops = 0;
    seen = 0;
    st[i] = 1'b1;
    while (!seen && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (!spam) st[i] = 1'b0;
      if (dn[i]) begin
        seen = 1;
        st[i] = 1'b0;
      end else if (!bsy[i]) begin
        drops++;
      end
    end
    st[i] = 1'b0;
    check($sformatf("latency%0d", i), cyc, exp_cyc);
    check($sformatf("busy_drop%0d", i), drops, 0);
    repeat (4) @(negedge clk);
    check($sformatf("done_cnt%0d", i), ndn[i] - d0, 1);
    check($sformatf("shifts%0d", i), nsh[i] - base, NB);
    check($sformatf("idle_busy%0d", i), bsy[i], 0);
    check($sformatf("idle_idx%0d", i), {ci1[i], ci2[i]}, 0);
  endtask

  task automatic check_words(input int i, input int base, input int tot);
    int off1;
    int off2;
    logic [12:0] w1;
    logic [12:0] w2;
    logic [12:0] e1;
    logic [12:0] e2;
    off1 = 0;
    off2 = 19 - (tot - 19);
    for (int k = 0; k < 19; k++) begin
      w1 = '0;
      w2 = '0;
      for (int b = 0; b < 13; b++) begin
        w1 = {w1[11:0], b1[i][base + 13 * k + b]};
        w2 = {w2[11:0], b2[i][base + 13 * k + b]};
      end
      e1 = (k < off1) ? 13'd0 : pat(18 - (k - off1));
      e2 = (k < off2) ? 13'd0 : pat(19 + k - off2);
      check($sformatf("u%0d_c1_w%0d", i, k), w1, e1);
      check($sformatf("u%0d_c2_w%0d", i, k), w2, e2);
    end
  endtask

  initial begin
    int base;
    int cyc;
    int ld0;
    repeat (3) @(negedge clk);
    check("rst_busy", bsy, 0);
    check("rst_done", dn, 0);
    check("rst_sclk", sclk, 0);
    check("rst_load", sld, 0);
    check("rst_data", {sd1, sd2}, 0);
    check("rst_sres", sres, 0);
    check("rst_idx", {ci1[0], ci2[0], ci1[2], ci2[2]}, 0);

    rstn = 1'b1;
    #1;
    check("sres_hold", sres, 0);
    @(negedge clk);
    check("sres_rel", sres, 3'b111);
    repeat (3) @(negedge clk);
    check("nostart_busy", bsy, 0);
    check("nostart_done", {ndn[0], ndn[1], ndn[2]}, 0);

    xfer(0, 2 * NB + 2, 1'b0, base);
    check_words(0, base, 38);

    xfer(0, 2 * NB + 2, 1'b1, base);
    check_words(0, base, 38);

    xfer(1, 2 * NB + 2, 1'b0, base);
    check_words(1, base, 37);

    xfer(2, 3 * (2 * NB + 1) + 1, 1'b0, base);
    check_words(2, base, 38);

    base = nsh[0];
    ld0 = nld[0];
    st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    cyc = 0;
    while (nsh[0] - base < 100 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check("abort_reach", (nsh[0] - base >= 100) ? 1 : 0, 1);
    rstn = 1'b0;
    @(negedge clk);
    check("abort_busy", bsy[0], 0);
    check("abort_sclk", sclk[0], 0);
    check("abort_data", {sd1[0], sd2[0]}, 0);
    check("abort_sres", sres[0], 0);
    check("abort_idx", {ci1[0], ci2[0]}, 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (10) @(negedge clk);
    check("abort_noload", nld[0] - ld0, 0);
    check("abort_nodone", dn[0], 0);

    xfer(0, 2 * NB + 2, 1'b0, base);
    check_words(0, base, 38);

    for (int i = 0; i < 3; i++) begin
      check($sformatf("clk_phase%0d", i), bad_run[i], 0);
      check($sformatf("load_len%0d", i), bad_ld[i], 0);
      check($sformatf("data_stable%0d", i), bad_dat[i], 0);
    end
    check("load_cycles_u2", nld[2], 3);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
